// File: rtl/div_pkg.sv
// Shared definitions for the memory-mapped unsigned divider.
// Contents: register select codes (addr[4:2]), STATUS bit positions and
// the controller state encoding.
package div_pkg;

   localparam logic [2:0] REG_A      = 3'd0;  // 0x00 dividend, RW
   localparam logic [2:0] REG_B      = 3'd1;  // 0x04 divisor, RW
   localparam logic [2:0] REG_INIT   = 3'd2;  // 0x08 start on d_in[0]=1, reads 0
   localparam logic [2:0] REG_STATUS = 3'd3;  // 0x0C status, RO
   localparam logic [2:0] REG_Q      = 3'd4;  // 0x10 quotient, RO
   localparam logic [2:0] REG_R      = 3'd5;  // 0x14 remainder, RO

   localparam int STAT_DONE = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_DIV0 = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract datapath: one quotient bit per step, MSB first.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i            capture operands, clear working remainder and counter
//   step_i            perform one shift-subtract iteration
//   dividend_i        dividend captured on load_i
//   divisor_i         divisor captured on load_i
//   quo_nxt_o         quotient after the current step (valid with last_o)
//   rem_nxt_o         remainder after the current step (valid with last_o)
//   last_o            the current step produces the final quotient bit
module div_core
   import div_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quo_nxt_o,
   output logic [DATA_W-1:0] rem_nxt_o,
   output logic              last_o
);

   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q;
   logic [CNT_W-1:0]  cnt_q;

   // The dividend is held in the quotient register and shifted out MSB
   // first while quotient bits shift in at the bottom.
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;
   logic            fits;

   always_comb begin
      shifted = {rem_q, quo_q[DATA_W-1]};
      diff    = shifted - {1'b0, dvs_q};
      fits    = ~diff[DATA_W];
      rem_d   = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_d   = {quo_q[DATA_W-2:0], fits};
   end

   assign quo_nxt_o = quo_d;
   assign rem_nxt_o = rem_d;
   assign last_o    = (cnt_q == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
         cnt_q <= '0;
      end else if (step_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         // Saturate at the final bit index; the controller leaves BUSY here.
         if (!last_o) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/peripheral_div.sv
// Memory-mapped unsigned divider peripheral.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   d_in         bus write data
//   cs           chip select for the peripheral region
//   addr         byte offset; addr[4:2] selects the register
//   rd, wr       read / write strobes, qualified by cs
//   d_out        registered read data, updated the cycle after cs&rd
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no result since reset, waiting for a start write
// BUSY    | division running, one quotient bit per cycle
// DONE    | Q/R valid (or divide-by-zero result), start may re-arm
module peripheral_div
   import div_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_in,
   input  logic              cs,
   input  logic [4:0]        addr,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] d_out
);

   div_state_e state_q, state_d;

   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] q_q, q_d;
   logic [DATA_W-1:0] r_q, r_d;
   logic              div0_q, div0_d;
   logic [DATA_W-1:0] d_out_q;

   logic              core_load, core_step, core_last;
   logic [DATA_W-1:0] core_quo, core_rem;

   logic       wr_en, rd_en, busy, done, start_wr;
   logic [2:0] reg_sel;
   logic       unused_addr;

   assign reg_sel     = addr[4:2];
   assign wr_en       = cs & wr;
   assign rd_en       = cs & rd;
   assign busy        = (state_q == ST_BUSY);
   assign done        = (state_q == ST_DONE);
   assign start_wr    = wr_en && (reg_sel == REG_INIT) && d_in[0];
   assign unused_addr = ^addr[1:0];

   div_core #(.DATA_W(DATA_W)) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (core_load),
      .step_i     (core_step),
      .dividend_i (a_q),
      .divisor_i  (b_q),
      .quo_nxt_o  (core_quo),
      .rem_nxt_o  (core_rem),
      .last_o     (core_last)
   );

   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      r_d       = r_q;
      div0_d    = div0_q;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_wr) begin
               if (b_q == '0) begin
                  // Divide by zero resolves immediately without a BUSY phase.
                  q_d     = '1;
                  r_d     = a_q;
                  div0_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  q_d       = '0;
                  r_d       = '0;
                  div0_d    = 1'b0;
                  core_load = 1'b1;
                  state_d   = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            core_step = 1'b1;
            if (core_last) begin
               q_d     = core_quo;
               r_d     = core_rem;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         div0_q  <= div0_d;
      end
   end

   // Operand registers are frozen while a division is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (wr_en && !busy) begin
         if (reg_sel == REG_A) a_q <= d_in;
         if (reg_sel == REG_B) b_q <= d_in;
      end
   end

   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      unique case (reg_sel)
         REG_A:      rd_mux = a_q;
         REG_B:      rd_mux = b_q;
         REG_STATUS: begin
            rd_mux[STAT_DONE] = done;
            rd_mux[STAT_BUSY] = busy;
            rd_mux[STAT_DIV0] = div0_q;
         end
         REG_Q:      rd_mux = q_q;
         REG_R:      rd_mux = r_q;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q <= '0;
      end else if (rd_en) begin
         d_out_q <= rd_mux;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_div.sv
module tb_peripheral_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] d_in = '0;
   logic        cs = 1'b0;
   logic [4:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] d_out;

   peripheral_div #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] OFF_A = 5'h00, OFF_B = 5'h04, OFF_INIT = 5'h08,
                          OFF_STAT = 5'h0C, OFF_Q = 5'h10, OFF_R = 5'h14;

   // ---------------- reference model ----------------
   // mode 0: nothing started, 1: normal division started at edge s,
   // 2: divide-by-zero result present.
   int          ec = 0;
   int          s = 0;
   int          mode = 0;
   logic [31:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
   logic        m_div0 = 1'b0;
   logic [31:0] last_dout = '0;

   function automatic logic m_busy();
      return (mode == 1) && ((ec - s) < 32);
   endfunction

   function automatic logic m_done();
      return (mode == 2) || ((mode == 1) && ((ec - s) >= 32));
   endfunction

   function automatic logic [31:0] rd_val(input logic [2:0] sel);
      case (sel)
         3'd0: return m_a;
         3'd1: return m_b;
         3'd3: return {29'd0, m_div0, m_busy(), m_done()};
         3'd4: return m_busy() ? 32'd0 : m_q;
         3'd5: return m_busy() ? 32'd0 : m_r;
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        fire = 1'b0;

   always @(posedge clk) fire = rd;

   always @(negedge clk) begin
      if (fire) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: d_out=%h but no expectation queued", "scoreboard", d_out);
         end else begin
            logic [31:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if (d_out !== e) begin
               n_bad++;
               $display("FAIL %s: got %h expected %h (t=%0t)", t, d_out, e, $time);
            end
         end
      end
   end

   // One bus cycle: drive at negedge, update the model for the next edge.
   task automatic tick(input logic c, input logic r, input logic w, input logic rs,
                       input logic [4:0] ad, input logic [31:0] dat, input string tag);
      logic bsy;
      @(negedge clk);
      cs = c; rd = r; wr = w; rst = rs; addr = ad; d_in = dat;
      if (rs) begin
         mode = 0; m_a = '0; m_b = '0; m_q = '0; m_r = '0; m_div0 = 1'b0;
         last_dout = '0;
         if (r) begin exp_q.push_back(last_dout); tag_q.push_back(tag); end
      end else begin
         if (r) begin
            if (c) last_dout = rd_val(ad[4:2]);
            exp_q.push_back(last_dout);
            tag_q.push_back(tag);
         end
         bsy = m_busy();
         if (c && w && !bsy) begin
            case (ad[4:2])
               3'd0: m_a = dat;
               3'd1: m_b = dat;
               3'd2: if (dat[0]) begin
                  if (m_b == 0) begin
                     mode = 2; m_q = 32'hFFFF_FFFF; m_r = m_a; m_div0 = 1'b1;
                  end else begin
                     mode = 1; s = ec + 1; m_q = m_a / m_b; m_r = m_a % m_b;
                     m_div0 = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
      @(posedge clk);
      ec++;
   endtask

   task automatic wr_reg(input logic [4:0] ad, input logic [31:0] dat);
      tick(1'b1, 1'b0, 1'b1, 1'b0, ad, dat, "write");
   endtask

   task automatic rd_reg(input logic [4:0] ad, input string tag);
      tick(1'b1, 1'b1, 1'b0, 1'b0, ad, 32'd0, tag);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "idle");
   endtask

   // Poll STATUS every cycle until the model says done (bounded), then read Q/R.
   task automatic poll_result(input string tag);
      int n;
      n = 0;
      while (!m_done() && n < 40) begin
         rd_reg(OFF_STAT, {tag, "_stat"});
         n++;
      end
      rd_reg(OFF_STAT, {tag, "_stat_done"});
      rd_reg(OFF_Q, {tag, "_q"});
      rd_reg(OFF_R, {tag, "_r"});
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
      wr_reg(OFF_A, a);
      wr_reg(OFF_B, b);
      wr_reg(OFF_INIT, 32'd1);
      poll_result(tag);
   endtask

   initial begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, "rst");
      tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, "rst");
      for (int i = 0; i < 8; i++) rd_reg(5'(i * 4), "reset_state");

      run_div(32'd100, 32'd7, "a100_b7");
      run_div(32'hFFFF_FFFF, 32'd1, "max_b1");
      run_div(32'd3, 32'd10, "a3_b10");

      // divide by zero, then a valid start must clear div0
      run_div(32'd5, 32'd0, "div0");
      run_div(32'd77, 32'd8, "after_div0");

      // operand/start writes while busy are ignored
      wr_reg(OFF_A, 32'd1000);
      wr_reg(OFF_B, 32'd9);
      wr_reg(OFF_INIT, 32'd1);
      for (int i = 0; i < 8; i++) rd_reg(OFF_STAT, "busy_stat");
      wr_reg(OFF_A, 32'd1);
      wr_reg(OFF_B, 32'd1);
      wr_reg(OFF_INIT, 32'd1);
      rd_reg(OFF_A, "busy_a_hold");
      rd_reg(OFF_B, "busy_b_hold");
      poll_result("busy_writes");

      // reset in the middle of a division
      wr_reg(OFF_A, 32'd1000);
      wr_reg(OFF_B, 32'd9);
      wr_reg(OFF_INIT, 32'd1);
      for (int i = 0; i < 13; i++) idle();
      tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, "mid_rst");
      rd_reg(OFF_STAT, "rst_stat");
      rd_reg(OFF_Q, "rst_q");
      rd_reg(OFF_R, "rst_r");
      run_div(32'd1000, 32'd9, "after_rst");

      // reset wins over a simultaneous start write
      wr_reg(OFF_A, 32'd50);
      wr_reg(OFF_B, 32'd5);
      tick(1'b1, 1'b0, 1'b1, 1'b1, OFF_INIT, 32'd1, "rst_start");
      rd_reg(OFF_STAT, "rst_start_stat");
      rd_reg(OFF_A, "rst_start_a");

      // cs=0 accesses
      wr_reg(OFF_A, 32'h1234_5678);
      rd_reg(OFF_A, "cs_a");
      tick(1'b0, 1'b1, 1'b0, 1'b0, OFF_B, 32'd0, "cs0_read_hold");
      tick(1'b0, 1'b0, 1'b1, 1'b0, OFF_A, 32'hDEAD_BEEF, "cs0_write");
      tick(1'b0, 1'b0, 1'b1, 1'b0, OFF_B, 32'hCAFE_F00D, "cs0_write");
      rd_reg(OFF_A, "cs0_a_kept");
      rd_reg(OFF_B, "cs0_b_kept");
      rd_reg(5'h18, "unused_18");
      rd_reg(5'h1C, "unused_1c");

      // randomized operands with random bus noise while running
      for (int it = 0; it < 25; it++) begin
         logic [31:0] a, b;
         int sel;
         a = $urandom;
         sel = $urandom_range(0, 7);
         b = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 15)) : $urandom;
         wr_reg(OFF_A, a);
         wr_reg(OFF_B, b);
         wr_reg(OFF_INIT, 32'd1);
         for (int k = 0; k < 34; k++) begin
            logic [4:0] ad;
            ad = 5'($urandom_range(0, 7) * 4);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, 1'b0, ad, $urandom, "rand_bus");
         end
         poll_result("rand");
      end

      idle();
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/peripheral_div.md
PERIPHERAL_DIV -- requirements
Module: peripheral_div

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port d_in  input  32  bus write data.
REQ-005 SHALL have port cs  input  1  chip select, asserted for bus region 0x0043xxxx.
REQ-006 SHALL have port addr  input  5  byte offset within the region; addr[4:2] selects the register.
REQ-007 SHALL have port rd  input  1  read strobe, qualified by cs.
REQ-008 SHALL have port wr  input  1  write strobe, qualified by cs.
REQ-009 SHALL have port d_out  output  32  registered read data.

Function
REQ-010 SHALL implement this register map:
- 0x00 A: dividend, RW.
- 0x04 B: divisor, RW.
- 0x08 INIT: write with d_in[0]=1 starts; reads 0.
- 0x0C STATUS: RO, bit0 done, bit1 busy, bit2 div0, other bits 0.
- 0x10 Q: quotient, RO.
- 0x14 R: remainder, RO.
- 0x18, 0x1C: read 0, writes ignored.
REQ-011 SHALL perform an unsigned DATA_W-bit restoring shift-subtract division, one quotient bit per cycle, MSB first.
REQ-012 SHALL use a three-state FSM with IDLE, BUSY and DONE states.
- IDLE->BUSY on a start write.
- BUSY->DONE when the bit counter reaches DATA_W-1.
- DONE->BUSY on a start write.
- No other transitions except reset.
REQ-013 SHALL latch A and B into internal working registers on the start cycle; later writes to A/B do not affect a running division.
REQ-014 SHALL assert done exactly DATA_W+1 cycles after the start-write cycle, with Q and R valid in that same cycle.
REQ-015 SHALL ignore start writes and A/B writes while busy=1.
REQ-016 SHALL clear done, div0, Q and R on an accepted start.
REQ-017 SHALL handle divisor 0 without entering BUSY: on the cycle after start, Q=all-ones, R=A, div0=1, done=1, state=DONE.
REQ-018 SHALL update d_out one cycle after a cycle with cs&rd, with the addressed register's value, and hold it otherwise.
REQ-019 SHALL ignore rd/wr when cs=0.
REQ-020 SHALL give a write priority over the FSM only where REQ-015 allows it.
REQ-021 SHALL keep the counter 6 bits wide (for DATA_W=32), with no wrap beyond DATA_W-1.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set the following to zero and return to IDLE, aborting any division in progress:
- A, B, Q, R;
- working registers and counter;
- done, busy, div0;
- d_out.
REQ-023 SHALL, when rst is asserted and a start write occurs in the same cycle, give reset precedence.

Structure
REQ-024 SHALL place register offsets, STATUS bit positions and FSM state encodings in shared package div_pkg.
REQ-025 SHALL split the datapath into one sub-module div_core (working remainder/quotient shift-subtract and counter), controlled by the FSM in peripheral_div.

Verification
REQ-026 SHALL cover: A=100, B=7, start; STATUS polled -> done=1 at cycle 33, Q=14, R=2.
REQ-027 SHALL cover: A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0; then A=3, B=10 -> Q=0, R=3.
REQ-028 SHALL cover: A=5, B=0 -> at cycle 1 done=1, div0=1, Q=0xFFFFFFFF, R=5; the next valid start clears div0.
REQ-029 SHALL cover: A=1000, B=9, start; at cycle 10 write A=1, B=1 and start again -> both writes ignored, Q=111, R=1 at cycle 33.
REQ-030 SHALL cover: A=1000, B=9, start; rst at cycle 15 -> STATUS=0, Q=0, R=0, and a fresh start completes correctly.
REQ-031 SHALL cover: read with cs=0 -> d_out unchanged; writes with cs=0 leave A/B unchanged.
